// File: rtl/cmd_rcv_pkg.sv
// Shared types and constants for the SUMP command receiver.
package cmd_rcv_pkg;

  localparam int CMD_LONG_BIT      = 7;
  localparam int CMD_PAYLOAD_BYTES = 4;
  localparam int CMD_BCNT_W        = $clog2(CMD_PAYLOAD_BYTES);

  typedef enum logic {IDLE = 1'b0, PAYLOAD = 1'b1} cmd_rcv_state_t;
  typedef logic [31:0]           cmd_payload_t;
  typedef logic [CMD_BCNT_W-1:0] cmd_bcnt_t;

  localparam cmd_bcnt_t CMD_LAST_BYTE = cmd_bcnt_t'(CMD_PAYLOAD_BYTES - 1);

  // Payload is little-endian: byte k lands at bits [8k+7:8k].
  function automatic cmd_payload_t put_byte(cmd_payload_t word, cmd_bcnt_t idx, logic [7:0] b);
    cmd_payload_t w;
    w = word;
    w[{idx, 3'b000} +: 8] = b;
    return w;
  endfunction

endpackage

// File: rtl/cmd_rcv_if.sv
// Byte-stream input and strobed command output of the command receiver.
interface cmd_rcv_if;
  import cmd_rcv_pkg::*;

  logic         rx_stb_i;
  logic [7:0]   rx_dat_i;
  logic         stb_o;
  logic [7:0]   opc_o;
  cmd_payload_t cmd_o;
  logic         busy_o;
  logic         err_o;

  modport master (
    output rx_stb_i, rx_dat_i,
    input  stb_o, opc_o, cmd_o, busy_o, err_o
  );

  modport slave (
    input  rx_stb_i, rx_dat_i,
    output stb_o, opc_o, cmd_o, busy_o, err_o
  );

endinterface

// File: rtl/tmo_cnt.sv
// Saturating inactivity counter; expired is high once TIMEOUT_CYCLES-1 idle cycles are counted.
module tmo_cnt #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk_i,
  input  logic rst_in,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_EXP = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT = {CW{1'b1}};

  logic [CW-1:0] cnt_r;

  // Count enabled idle cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en && (cnt_r != CNT_SAT)) begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  assign expired = (cnt_r >= CNT_EXP);

endmodule

// File: rtl/cmd_rcv.sv
// Assembles short (1-byte) and long (opcode + 4 payload bytes) SUMP commands
// and presents each as a single strobe; stale partial long commands are dropped.
module cmd_rcv
  import cmd_rcv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic     clk_i,
  input  logic     rst_in,
  cmd_rcv_if.slave bus
);

  cmd_rcv_state_t state_r, state_s;
  cmd_bcnt_t      bcnt_r, bcnt_s;
  logic [7:0]     opc_lat_r, opc_lat_s;
  cmd_payload_t   shadow_r, shadow_s;
  logic           stb_r, stb_s;
  logic [7:0]     opc_r, opc_s;
  cmd_payload_t   cmd_r, cmd_s;
  logic           busy_r;
  logic           err_r, err_s;
  logic           tmo_clr_s, tmo_en_s, tmo_exp_s;

  tmo_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk_i   (clk_i),
    .rst_in  (rst_in),
    .clr     (tmo_clr_s),
    .en      (tmo_en_s),
    .expired (tmo_exp_s)
  );

  // Next-state and next-output logic; an arriving byte always wins over expiry.
  always_comb begin
    state_s   = state_r;
    bcnt_s    = bcnt_r;
    opc_lat_s = opc_lat_r;
    shadow_s  = shadow_r;
    stb_s     = 1'b0;
    err_s     = 1'b0;
    opc_s     = opc_r;
    cmd_s     = cmd_r;
    tmo_clr_s = 1'b1;
    tmo_en_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.rx_stb_i) begin
          if (bus.rx_dat_i[CMD_LONG_BIT]) begin
            opc_lat_s = bus.rx_dat_i;
            bcnt_s    = '0;
            shadow_s  = 32'h0000_0000;
            state_s   = PAYLOAD;
          end else begin
            stb_s = 1'b1;
            opc_s = bus.rx_dat_i;
            cmd_s = 32'h0000_0000;
          end
        end else begin
          state_s = IDLE;
        end
      end
      PAYLOAD: begin
        if (bus.rx_stb_i) begin
          shadow_s = put_byte(shadow_r, bcnt_r, bus.rx_dat_i);
          if (bcnt_r == CMD_LAST_BYTE) begin
            stb_s   = 1'b1;
            opc_s   = opc_lat_r;
            cmd_s   = shadow_s;
            bcnt_s  = '0;
            state_s = IDLE;
          end else begin
            bcnt_s = bcnt_r + 1'b1;
          end
        end else if (tmo_exp_s) begin
          err_s   = 1'b1;
          state_s = IDLE;
        end else begin
          tmo_clr_s = 1'b0;
          tmo_en_s  = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, assembly and output registers.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_r   <= IDLE;
      bcnt_r    <= '0;
      opc_lat_r <= 8'h00;
      shadow_r  <= 32'h0000_0000;
      stb_r     <= 1'b0;
      opc_r     <= 8'h00;
      cmd_r     <= 32'h0000_0000;
      busy_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      bcnt_r    <= bcnt_s;
      opc_lat_r <= opc_lat_s;
      shadow_r  <= shadow_s;
      stb_r     <= stb_s;
      opc_r     <= opc_s;
      cmd_r     <= cmd_s;
      busy_r    <= (state_s == PAYLOAD);
      err_r     <= err_s;
    end
  end

  assign bus.stb_o  = stb_r;
  assign bus.opc_o  = opc_r;
  assign bus.cmd_o  = cmd_r;
  assign bus.busy_o = busy_r;
  assign bus.err_o  = err_r;

endmodule
